gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 129 ++++++++++++
 tb/tb_gate_truth_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// Sweeps {A,B} through 00..11 into an external 2-input gate and compares Y0 against the selected function.
// DONE rises 4*SETTLE_CYC cycles after an accepted START; START is ignored while BUSY is high.
module gate_truth_checker #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [2:0] OP,
    input  logic       Y0,
    output logic       A,
    output logic       B,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [2:0] ERR_CNT,
    output logic [3:0] FAIL_VEC
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] OP_ILLEGAL  = 3'd7;

    state_t     state, state_nx;
    logic [2:0] op_q, op_nx;
    logic [1:0] idx, idx_nx;
    logic [3:0] cyc, cyc_nx;
    logic [2:0] err, err_nx;
    logic [3:0] fv, fv_nx;
    logic       pass, pass_nx;
    logic       expect_y;

    // idx is the combination currently on the pins; it only reaches the pins during RUN
    always_comb begin
        expect_y = 1'b0;
        case (op_q)
            3'd0:    expect_y = idx[1] & idx[0];
            3'd1:    expect_y = idx[1] | idx[0];
            3'd2:    expect_y = ~idx[1];
            3'd3:    expect_y = ~(idx[1] | idx[0]);
            3'd4:    expect_y = ~(idx[1] & idx[0]);
            3'd5:    expect_y = idx[1] ^ idx[0];
            3'd6:    expect_y = ~(idx[1] ^ idx[0]);
            default: expect_y = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        idx_nx   = idx;
        cyc_nx   = cyc;
        err_nx   = err;
        fv_nx    = fv;
        pass_nx  = pass;
        case (state)
            IDLE, REPORT: begin
                if (state == REPORT) state_nx = IDLE;
                if (START) begin
                    op_nx   = OP;
                    idx_nx  = 2'd0;
                    cyc_nx  = 4'd0;
                    err_nx  = 3'd0;
                    fv_nx   = 4'd0;
                    pass_nx = 1'b0;
                    if (OP == OP_ILLEGAL) begin
                        state_nx = REPORT;
                        err_nx   = 3'd4;
                        fv_nx    = 4'hF;
                    end else begin
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (cyc == SETTLE_LAST) begin
                    cyc_nx = 4'd0;
                    if (Y0 != expect_y) begin
                        fv_nx  = fv | (4'b0001 << idx);
                        err_nx = err + 3'd1;
                    end
                    if (idx == 2'd3) begin
                        state_nx = REPORT;
                        pass_nx  = (err_nx == 3'd0);
                    end else begin
                        idx_nx = idx + 2'd1;
                    end
                end else begin
                    cyc_nx = cyc + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            op_q  <= 3'd0;
            idx   <= 2'd0;
            cyc   <= 4'd0;
            err   <= 3'd0;
            fv    <= 4'd0;
            pass  <= 1'b0;
        end else begin
            state <= state_nx;
            op_q  <= op_nx;
            idx   <= idx_nx;
            cyc   <= cyc_nx;
            err   <= err_nx;
            fv    <= fv_nx;
            pass  <= pass_nx;
        end
    end

    assign A        = (state == RUN) & idx[1];
    assign B        = (state == RUN) & idx[0];
    assign BUSY     = (state == RUN);
    assign DONE     = (state == REPORT);
    assign PASS     = pass;
    assign ERR_CNT  = err;
    assign FAIL_VEC = fv;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: one instance with SETTLE_CYC=1, one with SETTLE_CYC=3, each driving a modelled gate.
module tb_gate_truth_checker;

    typedef struct {
        logic [2:0] op;
        int         model;
        logic [3:0] fv;
        logic [2:0] ec;
        logic       pass;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] fv;
        logic [2:0] ec;
        logic       pass;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [2:0] op1 = 3'd0, op3 = 3'd0;
    int         model1 = 0, model3 = 0;
    logic       y0_1, y0_3;
    logic       a1, b1, busy1, done1, pass1;
    logic       a3, b3, busy3, done3, pass3;
    logic [2:0] err1, err3;
    logic [3:0] fv1, fv3;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[9];

    always #5 CLK = ~CLK;

    // model codes 0..6 follow the OP encoding; 8 is stuck-at-0, 9 is stuck-at-1
    function automatic logic gmodel(input int m, input logic a, input logic b);
        case (m)
            0:       return a & b;
            1:       return a | b;
            2:       return !a;
            3:       return !(a | b);
            4:       return !(a & b);
            5:       return a ^ b;
            6:       return !(a ^ b);
            9:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign y0_1 = gmodel(model1, a1, b1);
    assign y0_3 = gmodel(model3, a3, b3);

    gate_truth_checker #(.SETTLE_CYC(1)) dut1 (
        .CLK(CLK), .RST(RST), .START(start1), .OP(op1), .Y0(y0_1),
        .A(a1), .B(b1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .ERR_CNT(err1), .FAIL_VEC(fv1)
    );

    gate_truth_checker #(.SETTLE_CYC(3)) dut3 (
        .CLK(CLK), .RST(RST), .START(start3), .OP(op3), .Y0(y0_3),
        .A(a3), .B(b3), .BUSY(busy3), .DONE(done3), .PASS(pass3),
        .ERR_CNT(err3), .FAIL_VEC(fv3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pop_cmp(input string nm, input logic [3:0] fv, input logic [2:0] ec, input logic ps);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty at DONE", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, " fail_vec"}, fv, e.fv);
            chk({nm, " err_cnt"}, ec, e.ec);
            chk({nm, " pass"}, ps, e.pass);
        end
    endtask

    task automatic run1(input vec_t v);
        exp_t e;
        int   k;
        int   n;
        logic [3:0] mask;
        op1    = v.op;
        model1 = v.model;
        start1 = 1'b1;
        e.fv = v.fv; e.ec = v.ec; e.pass = v.pass;
        sb.push_back(e);
        tick();
        start1 = 1'b0;
        op1    = ~v.op;
        k = 0;
        while (!done1 && k < 20) begin
            mask = 4'((1 << k) - 1);
            n = 0;
            for (int j = 0; j < 4; j++) if (j < k && v.fv[j]) n++;
            chk({v.name, " busy"}, busy1, 1);
            chk({v.name, " ab"}, {a1, b1}, k[1:0]);
            chk({v.name, " mid fail_vec"}, fv1, v.fv & mask);
            chk({v.name, " mid err_cnt"}, err1, n);
            chk({v.name, " mid pass"}, pass1, 0);
            tick();
            k++;
        end
        chk({v.name, " latency"}, k, (v.op == 3'd7) ? 0 : 4);
        pop_cmp(v.name, fv1, err1, pass1);
        chk({v.name, " busy at done"}, busy1, 0);
        chk({v.name, " ab at done"}, {a1, b1}, 0);
        tick();
        chk({v.name, " done width"}, done1, 0);
        chk({v.name, " hold fail_vec"}, fv1, v.fv);
        chk({v.name, " hold err_cnt"}, err1, v.ec);
        chk({v.name, " hold pass"}, pass1, v.pass);
    endtask

    task automatic wait3(input string nm, input int pulse_at);
        int k;
        int c;
        k = 0;
        while (!done3 && k < 40) begin
            c = k / 3;
            chk({nm, " busy"}, busy3, 1);
            chk({nm, " ab"}, {a3, b3}, c[1:0]);
            chk({nm, " mid pass"}, pass3, 0);
            start3 = (k == pulse_at);
            tick();
            k++;
        end
        start3 = 1'b0;
        chk({nm, " latency"}, k, 12);
        pop_cmp(nm, fv3, err3, pass3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   seen;
        vecs[0] = '{3'd0, 0, 4'b0000, 3'd0, 1'b1, "and_ideal"};
        vecs[1] = '{3'd5, 1, 4'b1000, 3'd1, 1'b0, "xor_vs_or"};
        vecs[2] = '{3'd2, 8, 4'b0011, 3'd2, 1'b0, "nota_stuck0"};
        vecs[3] = '{3'd7, 0, 4'b1111, 3'd4, 1'b0, "illegal_op"};
        vecs[4] = '{3'd3, 4, 4'b0110, 3'd2, 1'b0, "nor_vs_nand"};
        vecs[5] = '{3'd4, 9, 4'b1000, 3'd1, 1'b0, "nand_stuck1"};
        vecs[6] = '{3'd6, 5, 4'b1111, 3'd4, 1'b0, "xnor_vs_xor"};
        vecs[7] = '{3'd1, 1, 4'b0000, 3'd0, 1'b1, "or_ideal"};
        vecs[8] = '{3'd2, 2, 4'b0000, 3'd0, 1'b1, "nota_ideal"};

        #2;
        chk("reset busy", busy1, 0);
        chk("reset done", done1, 0);
        chk("reset ab", {a1, b1}, 0);
        chk("reset pass", pass1, 0);
        chk("reset err_cnt", err1, 0);
        chk("reset fail_vec", fv1, 0);
        tick();
        RST = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run1(vecs[i]);

        // SETTLE_CYC=3: re-pulse mid-run is ignored, then START in REPORT chains a second run
        op3 = 3'd6; model3 = 6; start3 = 1'b1;
        e.fv = 4'b0000; e.ec = 3'd0; e.pass = 1'b1;
        sb.push_back(e);
        tick();
        start3 = 1'b0;
        op3 = 3'd0;
        wait3("s3_xnor", 5);
        op3 = 3'd6; model3 = 9; start3 = 1'b1;
        e.fv = 4'b0110; e.ec = 3'd2; e.pass = 1'b0;
        sb.push_back(e);
        tick();
        start3 = 1'b0;
        op3 = 3'd1;
        chk("b2b busy", busy3, 1);
        chk("b2b err cleared", err3, 0);
        chk("b2b fail_vec cleared", fv3, 0);
        chk("b2b pass cleared", pass3, 0);
        wait3("s3_xnor_stuck1", -1);

        // reset two cycles into a failing run
        op1 = 3'd6; model1 = 5; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("prereset err_cnt", err1, 2);
        chk("prereset fail_vec", fv1, 4'b0011);
        #1 RST = 1'b1;
        #1;
        chk("async rst busy", busy1, 0);
        chk("async rst done", done1, 0);
        chk("async rst ab", {a1, b1}, 0);
        chk("async rst err_cnt", err1, 0);
        chk("async rst fail_vec", fv1, 0);
        chk("async rst pass", pass1, 0);
        tick();
        RST = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            if (done1) seen = 1;
        end
        chk("aborted run done", seen, 0);
        run1('{3'd1, 1, 4'b0000, 3'd0, 1'b1, "or_after_reset"});

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
